// File: rtl/dac_pkg.sv
// Shared types and constants for the HSMC DAC transmit path.
package dac_pkg;

  localparam int DAC_DATA_W = 14;
  localparam logic [DAC_DATA_W-1:0] DAC_MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } dac_state_e;

  // Occupancy counter width: one extra bit so "full" is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample-pair FIFO with flush; pointers carry an extra wrap bit
// so occupancy is simply the pointer difference.
module dac_sample_fifo
  import dac_pkg::*;
#(
  parameter int WIDTH = 2 * DAC_DATA_W,
  parameter int DEPTH = 16
) (
  input  logic                     CLK_65,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  assign level   = wr_ptr_r - rd_ptr_r;
  assign full_s  = level[AW];
  assign empty_s = (level == {(AW+1){1'b0}});
  assign push_s  = wr_en && !full_s && !flush;
  assign pop_s   = rd_en && !empty_s && !flush;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; flush discards everything including a same-cycle write.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array.
  always_ff @(posedge CLK_65) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dac_driver.sv
// Buffers A/B sample pairs and plays them to the HSMC DAC one pair per CLK_65.
// Optional build macro DAC_UNDERFLOW_COUNT_EN adds a saturating underflow_count port.
module dac_driver
  import dac_pkg::*;
#(
  parameter int                DATA_W     = DAC_DATA_W,
  parameter int                FIFO_DEPTH = 16,
  parameter int                PREFILL    = 8,
  parameter logic [DATA_W-1:0] MIDSCALE   = DAC_MIDSCALE
) (
  input  logic                              CLK_65,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [DATA_W-1:0]                 data_canal_a,
  input  logic [DATA_W-1:0]                 data_canal_b,
  input  logic                              data_valid,
  output logic                              data_ready,
  output logic [DATA_W-1:0]                 DAC_DA,
  output logic [DATA_W-1:0]                 DAC_DB,
  output logic                              DAC_CLK_A,
  output logic                              DAC_CLK_B,
  output logic                              DAC_WRT_A,
  output logic                              DAC_WRT_B,
  output logic                              underflow,
  output logic                              running,
  output logic [level_w(FIFO_DEPTH)-1:0]    fifo_level
`ifdef DAC_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]                       underflow_count
`endif
);

  localparam int LVL_W = level_w(FIFO_DEPTH);

  dac_state_e              state_r;
  dac_state_e              state_s;
  logic [LVL_W-1:0]        level_s;
  logic [2*DATA_W-1:0]     rd_data_s;
  logic [DATA_W-1:0]       dac_da_r;
  logic [DATA_W-1:0]       dac_db_r;
  logic                    underflow_r;
  logic                    flush_s;
  logic                    ready_s;
  logic                    push_s;
  logic                    empty_s;
  logic                    pop_s;
  logic                    uflow_s;

  assign flush_s = !enable || (state_r == ST_IDLE);
  assign empty_s = (level_s == {LVL_W{1'b0}});
  assign ready_s = enable && (state_r != ST_IDLE) && (level_s < LVL_W'(FIFO_DEPTH));
  assign push_s  = data_valid && ready_s;
  assign pop_s   = enable && (state_r == ST_RUN) && !empty_s;
  // Emptiness is judged on the pre-edge level, so a write landing now still underflows.
  assign uflow_s = enable && (state_r == ST_RUN) && empty_s;

  dac_sample_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK_65  (CLK_65),
    .reset_n (reset_n),
    .flush   (flush_s),
    .wr_en   (push_s),
    .wr_data ({data_canal_a, data_canal_b}),
    .rd_en   (pop_s),
    .rd_data (rd_data_s),
    .level   (level_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    if (!enable) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_FILL;
        ST_FILL: begin
          if (level_s >= LVL_W'(PREFILL)) state_s = ST_RUN;
          else                            state_s = ST_FILL;
        end
        ST_RUN: begin
          if (empty_s) state_s = ST_FILL;
          else         state_s = ST_RUN;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // DAC data: parked at mid-scale when idle, otherwise hold until a pop.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      dac_da_r <= MIDSCALE;
      dac_db_r <= MIDSCALE;
    end else if (flush_s) begin
      dac_da_r <= MIDSCALE;
      dac_db_r <= MIDSCALE;
    end else if (pop_s) begin
      dac_da_r <= rd_data_s[2*DATA_W-1:DATA_W];
      dac_db_r <= rd_data_s[DATA_W-1:0];
    end
  end

  // Sticky underflow flag, cleared only by leaving playback.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n)     underflow_r <= 1'b0;
    else if (flush_s) underflow_r <= 1'b0;
    else if (uflow_s) underflow_r <= 1'b1;
  end

`ifdef DAC_UNDERFLOW_COUNT_EN
  logic [15:0] uflow_cnt_r;

  // Saturating underflow event counter.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n)                                uflow_cnt_r <= 16'h0000;
    else if (flush_s)                            uflow_cnt_r <= 16'h0000;
    else if (uflow_s && uflow_cnt_r != 16'hFFFF) uflow_cnt_r <= uflow_cnt_r + 16'h0001;
  end

  assign underflow_count = uflow_cnt_r;
`endif

  assign data_ready = ready_s;
  assign DAC_DA     = dac_da_r;
  assign DAC_DB     = dac_db_r;
  assign DAC_CLK_A  = ~CLK_65;
  assign DAC_CLK_B  = ~CLK_65;
  assign DAC_WRT_A  = ~CLK_65;
  assign DAC_WRT_B  = ~CLK_65;
  assign underflow  = underflow_r;
  assign running    = (state_r == ST_RUN);
  assign fifo_level = level_s;

endmodule
